// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM arbiter slice.
//   AW/DW/DEPTH : default address width, data width, valid word count
//   RD_LAT      : grant-to-rvalid latency in cycles
//   WE_DLY      : grant-to-sram_we delay in cycles
//   rd_tag_t    : {valid, requester id} carried down the read-return pipe
package sram_pkg;

  localparam int unsigned AW     = 12;
  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned WE_DLY = 2;
  localparam int unsigned ID_W   = 3;   // enough for up to 8 requesters

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Round-robin arbiter with its own pointer register.
//   clk, rst : clock, synchronous active-high reset
//   req[N]   : request vector
//   gnt[N]   : one-hot combinational grant; zero while rst is high
// Search starts at ptr; the pointer moves to winner+1 and holds when idle.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Two passes: first indices at/above ptr, then wrap to those below it.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && (i >= 32'(ptr_q))) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          ptr_d  = (i + 1 == N) ? '0 : PW'(i + 1);
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          ptr_d  = (i + 1 == N) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one registered-address / negedge-data SRAM between NREQ requesters.
//   req/req_we/req_addr/req_wdata : per-requester request, held until gnt
//   gnt    : one-hot combinational grant
//   err    : pulse the cycle after an out-of-range request is granted
//   rvalid : one-hot read-return pulse, grant + RD_LAT; rdata alongside
//   sram_read_addr/sram_write_addr/sram_write_data : registered, grant + 1
//   sram_we : registered, grant + WE_DLY (after the SRAM has latched addr/data)
//   sram_read_data : SRAM output, valid after its negedge
module sram_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned AW    = sram_pkg::AW,
  parameter int unsigned DW    = sram_pkg::DW,
  parameter int unsigned DEPTH = sram_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    err,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      sram_read_addr,
  output logic [AW-1:0]      sram_write_addr,
  output logic [DW-1:0]      sram_write_data,
  output logic               sram_we,
  input  logic [DW-1:0]      sram_read_data
);

  import sram_pkg::*;

  logic [ID_W-1:0] sel_id;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            any_gnt;
  logic            in_range;

  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic [WE_DLY-1:0] we_sr_q, we_sr_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  // First RD_LAT-1 stages of the read-return shift; rvalid_q is the last stage.
  rd_tag_t [RD_LAT-2:0] pipe_q, pipe_d;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  always_comb begin
    sel_id    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_id    = ID_W'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  assign any_gnt  = |gnt;
  assign in_range = (32'(sel_addr) < DEPTH);

  always_comb begin
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we_sr_d   = {we_sr_q[WE_DLY-2:0], 1'b0};
    err_d     = '0;
    pipe_d    = '0;
    rvalid_d  = '0;
    rdata_d   = rdata_q;

    if (any_gnt) begin
      if (!in_range) begin
        err_d = gnt;
      end else if (sel_we) begin
        wr_addr_d  = sel_addr;
        wr_data_d  = sel_wdata;
        we_sr_d[0] = 1'b1;
      end else begin
        rd_addr_d = sel_addr;
      end
    end

    pipe_d[0].vld = any_gnt && in_range && !sel_we;
    pipe_d[0].id  = sel_id;
    for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    // SRAM data settles at the negedge of the cycle this stage is valid.
    if (pipe_q[RD_LAT-2].vld) begin
      rdata_d = sram_read_data;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      rvalid_d[i] = pipe_q[RD_LAT-2].vld && (pipe_q[RD_LAT-2].id == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      we_sr_q   <= '0;
      err_q     <= '0;
      pipe_q    <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      we_sr_q   <= we_sr_d;
      err_q     <= err_d;
      pipe_q    <= pipe_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign sram_read_addr  = rd_addr_q;
  assign sram_write_addr = wr_addr_q;
  assign sram_write_data = wr_data_q;
  assign sram_we         = we_sr_q[WE_DLY-1];
  assign err             = err_q;
  assign rvalid          = rvalid_q;
  assign rdata           = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural negedge SRAM.
module tb_sram_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, err, rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      sram_read_addr, sram_write_addr;
  logic [DW-1:0]      sram_write_data;
  logic               sram_we;
  logic [DW-1:0]      sram_read_data;

  always #5 clk = ~clk;

  sram_arbiter #(
    .NREQ  (NREQ),
    .AW    (AW),
    .DW    (DW),
    .DEPTH (512)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .gnt             (gnt),
    .err             (err),
    .rvalid          (rvalid),
    .rdata           (rdata),
    .sram_read_addr  (sram_read_addr),
    .sram_write_addr (sram_write_addr),
    .sram_write_data (sram_write_data),
    .sram_we         (sram_we),
    .sram_read_data  (sram_read_data)
  );

  // SRAM: addresses/data registered at posedge, access at negedge.
  logic [DW-1:0] mem [0:4095];
  logic [AW-1:0] m_raddr = '0, m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    sram_read_data = '0;
  end
  always @(posedge clk) begin
    m_raddr <= sram_read_addr;
    m_waddr <= sram_write_addr;
    m_wdata <= sram_write_data;
  end
  always @(negedge clk) begin
    if (sram_we) mem[m_waddr] <= m_wdata;
    sram_read_data <= mem[m_raddr];
  end

  typedef struct packed {
    int unsigned id;
    logic [31:0] data;
    int unsigned due;
  } rd_exp_t;
  typedef struct packed {
    int unsigned id;
    int unsigned due;
  } err_exp_t;

  rd_exp_t     rdq[$];
  err_exp_t    errq[$];
  int unsigned wq[$];

  logic [DW-1:0]   shadow [0:511];
  int unsigned     cyc = 0;
  int unsigned     mptr;
  logic [NREQ-1:0] sticky;
  logic            mon_en;
  int unsigned     n_vec = 0;
  int unsigned     n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle output monitor, sampled on the negedge.
  rd_exp_t         mon_r;
  err_exp_t        mon_e;
  logic            exp_we;
  logic [NREQ-1:0] exp_err;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rdq.size() != 0 && rdq[0].due <= cyc) begin
        mon_r = rdq.pop_front();
        check("rvalid", 64'(rvalid), 64'(1) << mon_r.id);
        check("rdata", 64'(rdata), 64'(mon_r.data));
      end else begin
        check("rvalid_idle", 64'(rvalid), 64'(0));
      end
      exp_err = '0;
      while (errq.size() != 0 && errq[0].due <= cyc) begin
        mon_e = errq.pop_front();
        exp_err[mon_e.id] = 1'b1;
      end
      check("err", 64'(err), 64'(exp_err));
      exp_we = 1'b0;
      while (wq.size() != 0 && wq[0] <= cyc) begin
        void'(wq.pop_front());
        exp_we = 1'b1;
      end
      check("sram_we", 64'(sram_we), 64'(exp_we));
    end
  end

  task automatic issue(input int unsigned i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req[i]                = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Entered at posedge+1 with this cycle's inputs driven; returns at the next posedge+1.
  task automatic tick();
    logic [NREQ-1:0] eg;
    int unsigned     w;
    logic            was_rst;
    logic [AW-1:0]   a;
    eg      = '0;
    w       = 0;
    was_rst = rst;
    #1;
    if (!rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        int unsigned ix;
        ix = (mptr + k) % NREQ;
        if (eg == '0 && req[ix]) begin
          eg[ix] = 1'b1;
          w      = ix;
        end
      end
    end
    check("gnt", 64'(gnt), 64'(eg));
    if (rst) begin
      mptr = 0;
    end else if (eg != '0) begin
      mptr = (w + 1) % NREQ;
      a = req_addr[w*AW +: AW];
      if (a >= 512) begin
        errq.push_back('{id: w, due: cyc + 1});
      end else if (req_we[w]) begin
        shadow[a[8:0]] = req_wdata[w*DW +: DW];
        wq.push_back(cyc + 2);
      end else begin
        rdq.push_back('{id: w, data: shadow[a[8:0]], due: cyc + 3});
      end
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      rdq.delete();
      errq.delete();
      wq.delete();
    end
    if (eg != '0 && !sticky[w]) req[w] = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_raddr"}, 64'(sram_read_addr), 64'(0));
    check({tag, "_waddr"}, 64'(sram_write_addr), 64'(0));
    check({tag, "_wdata"}, 64'(sram_write_data), 64'(0));
    check({tag, "_we"}, 64'(sram_we), 64'(0));
    check({tag, "_rdata"}, 64'(rdata), 64'(0));
    check({tag, "_rvalid"}, 64'(rvalid), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
  endtask

  logic [DW-1:0] saved;

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    sticky    = '0;
    mon_en    = 1'b0;
    mptr      = 0;
    for (int i = 0; i < 512; i++) shadow[i] = '0;

    // Reset: grants suppressed, registered outputs cleared.
    @(posedge clk);
    #1;
    req = '1;
    #1;
    check("gnt_in_rst", 64'(gnt), 64'(0));
    @(posedge clk);
    #1;
    req = '0;
    check_outputs_zero("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single write then read.
    issue(0, 1'b1, 12'h010, 32'hDEADBEEF);
    tick();
    idle(2);
    issue(0, 1'b0, 12'h010, '0);
    tick();
    idle(4);

    // Preload then full contention with all requesters holding req.
    issue(0, 1'b1, 12'h001, 32'hA);
    tick();
    issue(1, 1'b1, 12'h002, 32'hB);
    tick();
    issue(2, 1'b1, 12'h003, 32'hC);
    tick();
    idle(2);
    sticky = '1;
    issue(0, 1'b0, 12'h001, '0);
    issue(1, 1'b0, 12'h002, '0);
    issue(2, 1'b0, 12'h003, '0);
    repeat (4) tick();
    sticky = '0;
    req    = '0;
    idle(4);

    // Back-to-back read-after-write from different requesters.
    issue(1, 1'b1, 12'h020, 32'h5);
    tick();
    issue(2, 1'b0, 12'h020, '0);
    tick();
    idle(4);

    // Out of range read and write, then confirm memory untouched.
    issue(0, 1'b0, 12'h200, '0);
    tick();
    issue(1, 1'b1, 12'hFFF, 32'h12345678);
    tick();
    idle(3);
    issue(0, 1'b0, 12'h010, '0);
    tick();
    issue(0, 1'b0, 12'h1FF, '0);
    tick();
    idle(4);

    // Lone requester granted every cycle.
    sticky[0] = 1'b1;
    issue(0, 1'b0, 12'h002, '0);
    repeat (3) tick();
    sticky = '0;
    req    = '0;
    idle(4);

    // Reset with a read and a write in flight: both dropped.
    saved = shadow[9'h030];
    issue(1, 1'b0, 12'h002, '0);
    issue(0, 1'b1, 12'h030, 32'hBADC0DE);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    shadow[9'h030] = saved;
    check_outputs_zero("midrst");
    issue(0, 1'b0, 12'h030, '0);
    issue(1, 1'b0, 12'h002, '0);
    issue(2, 1'b0, 12'h003, '0);
    repeat (3) tick();
    idle(4);

    // Withdrawn request never granted and pointer left alone.
    issue(0, 1'b0, 12'h010, '0);
    issue(2, 1'b0, 12'h002, '0);
    tick();
    req[2] = 1'b0;
    tick();
    issue(0, 1'b0, 12'h003, '0);
    issue(1, 1'b0, 12'h001, '0);
    tick();
    tick();
    idle(5);

    check("rd_pending", 64'(rdq.size()), 64'(0));
    check("we_pending", 64'(wq.size()), 64'(0));
    check("err_pending", 64'(errq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
